sort_pulse_scheduler: RTL

SORT_PULSE_SCHEDULER -- requirements
Module: sort_pulse_scheduler

---
 rtl/sort_pulse_scheduler_if.sv | 24 ++
 rtl/sort_pulse_scheduler.sv | 107 ++++++++++
 2 files changed

// File: rtl/sort_pulse_scheduler_if.sv
// sort_pulse_scheduler_if: request, configuration and status bundle of the sort pulse scheduler.
interface sort_pulse_scheduler_if #(
    parameter int QSZ = 4,
    parameter int TW  = 32
);
    logic          sort_req_i;
    logic          cfg_enable_i;
    logic          cfg_clear_i;
    logic [TW-1:0] cfg_delay_i;
    logic [TW-1:0] cfg_duration_i;
    logic          sort_trig_o;
    logic [QSZ:0]  q_level_o;
    logic [TW-1:0] fired_cnt_o;
    logic [TW-1:0] dropped_cnt_o;
    logic [TW-1:0] late_cnt_o;
    modport master (
        output sort_req_i, cfg_enable_i, cfg_clear_i, cfg_delay_i, cfg_duration_i,
        input  sort_trig_o, q_level_o, fired_cnt_o, dropped_cnt_o, late_cnt_o
    );
    modport slave (
        input  sort_req_i, cfg_enable_i, cfg_clear_i, cfg_delay_i, cfg_duration_i,
        output sort_trig_o, q_level_o, fired_cnt_o, dropped_cnt_o, late_cnt_o
    );
endinterface

// File: rtl/sort_pulse_scheduler.sv
// sort_pulse_scheduler: queues timestamped sort requests and fires delayed trigger pulses.
// Define SORT_SCHED_MERGE_EN to extend a running pulse with heads that fall due during it.
module sort_pulse_scheduler #(
    parameter int QSZ = 4,
    parameter int TW  = 32
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rstn_i,
    sort_pulse_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
    state_t         state_q, state_d;
    logic [TW-1:0]  ts_q, cnt_q, cnt_d;
    logic [TW-1:0]  fired_q, fired_d, dropped_q, dropped_d, late_q, late_d;
    logic [QSZ-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [QSZ:0]   lvl_q, lvl_d;
    logic           trig_q;
    logic [TW-1:0]  mem_q [2**QSZ];
    logic [TW-1:0]  age;
    logic           head_due, pop, late, push, accept, flush;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v, input logic en);
        return (en && v != '1) ? v + TW'(1) : v;
    endfunction

    // signed age keeps the due test correct across timestamp wrap
    assign age      = ts_q - mem_q[rd_q];
    assign head_due = (lvl_q != '0) && !age[TW-1];
    assign flush    = bus.cfg_clear_i || !bus.cfg_enable_i;
    assign push     = bus.sort_req_i && !flush;
    assign accept   = push && (!lvl_q[QSZ] || pop);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        late    = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                state_d = IDLE;
                if (head_due) begin
                    pop     = 1'b1;
                    late    = state_q == GAP;
                    state_d = bus.cfg_duration_i != '0 ? PULSE : IDLE;
                    cnt_d   = bus.cfg_duration_i;
                end
            end
            default: begin
`ifdef SORT_SCHED_MERGE_EN
                if (head_due) begin
                    pop   = 1'b1;
                    late  = 1'b1;
                    cnt_d = bus.cfg_duration_i;
                end else
`endif
                if (cnt_q <= TW'(1)) state_d = GAP;
                else cnt_d = cnt_q - TW'(1);
            end
        endcase
        wr_d      = flush ? '0 : wr_q + QSZ'(accept);
        rd_d      = flush ? '0 : rd_q + QSZ'(pop);
        lvl_d     = flush ? '0 : lvl_q + (QSZ+1)'(accept) - (QSZ+1)'(pop);
        fired_d   = bus.cfg_clear_i ? '0 : sat_inc(fired_q, pop && !flush);
        late_d    = bus.cfg_clear_i ? '0 : sat_inc(late_q, late && !flush);
        dropped_d = bus.cfg_clear_i ? '0 : sat_inc(dropped_q, push && !accept);
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ts_q      <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            lvl_q     <= '0;
            fired_q   <= '0;
            dropped_q <= '0;
            late_q    <= '0;
            trig_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ts_q      <= ts_q + TW'(1);
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            lvl_q     <= lvl_d;
            fired_q   <= fired_d;
            dropped_q <= dropped_d;
            late_q    <= late_d;
            trig_q    <= state_d == PULSE;
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (accept) mem_q[wr_q] <= ts_q + bus.cfg_delay_i;
    end

    assign bus.sort_trig_o   = trig_q;
    assign bus.q_level_o     = lvl_q;
    assign bus.fired_cnt_o   = fired_q;
    assign bus.dropped_cnt_o = dropped_q;
    assign bus.late_cnt_o    = late_q;
endmodule
